banco_reg_param: RTL and testbench
==================================

// Module: banco_reg_param
// PURPOSE
//  Parametrised register file for the MIPS datapath; successor to the fixed 64x32 bank.
//  Provides three combinational read ports (rs, rt, rd), two write ports (ALU and memory) and write-through bypass.
//  A post-reset sweep FSM initialises every register, replacing first-clock presetting.
//  Sits between decode (read addresses) and writeback (write ports).
// PARAMETERS
//  DATA_W    32   data width in bits
//  ADDR_W    6    register address width; DEPTH = 2**ADDR_W
//  ZERO_IDX  62   hardwired register: always reads 0, writes to it ignored
//  RA_IDX    61   return-address register, loaded with RA_INIT by the sweep
//  RA_INIT   255  sweep value for RA_IDX (all other registers sweep to 0)
// PORTS
//  clock     in   1       rising-edge clock
//  reset_n   in   1       asynchronous, active-low reset
//  RLe1      in   ADDR_W  read address A (rs)
//  RLe2      in   ADDR_W  read address B (rt)
//  RLe3      in   ADDR_W  read address C (rd)
//  EscreveA  in   1       write enable, port A (ALU)
//  REscA     in   ADDR_W  write address, port A
//  DadoA     in   DATA_W  write data, port A
//  EscreveB  in   1       write enable, port B (memory)
//  REscB     in   ADDR_W  write address, port B
//  DadoB     in   DATA_W  write data, port B
//  DadoLe1   out  DATA_W  read data A (combinational)
//  DadoLe2   out  DATA_W  read data B (combinational)
//  DadoLe3   out  DATA_W  read data C (combinational)
//  Pronto    out  1       1 = init sweep complete, bank operational
// BEHAVIOUR
//  - Reset (reset_n=0, async): FSM -> INIT, sweep counter -> 0, Pronto=0. Array is not reset.
//  - INIT: each clock writes array[cnt] = (cnt==RA_IDX ? RA_INIT : 0); cnt increments.
//    Exit on the edge that writes cnt = DEPTH-1: next state RUN, Pronto=1. Pronto rises exactly DEPTH clocks after reset release.
//  - INIT: EscreveA/EscreveB ignored; DadoLe1..3 forced to 0.
//  - RUN: terminal state; exited only by reset. reset_n low mid-sweep or mid-RUN restarts INIT from cnt=0.
//  - Write (RUN): on posedge, if EscreveX and REscX != ZERO_IDX, array[REscX] <= DadoX.
//    Both ports enabled at the same address: port B (memory) wins.
//  - Read (RUN): DadoLeN = 0 if RLeN == ZERO_IDX.
//    Else DadoB if EscreveB && REscB==RLeN.
//    Else DadoA if EscreveA && REscA==RLeN.
//    Else array[RLeN].
//  - Bypass makes a write visible on reads in the same cycle; the array holds it from the next cycle.
//  - Priority matches the write rule (B over A), so bypassed and stored values always agree.
//  - Writes to ZERO_IDX are never bypassed.
//  - RA_IDX is an ordinary register after the sweep; it is writable.
//  - All addresses are full range 0..DEPTH-1; there is no out-of-range case.
// TESTING
//  1 reset_n 0->1, hold idle: Pronto=0 for 64 clocks, 1 on 65th; RLe1=61 -> 255; RLe2=5 -> 0.
//  2 RUN, EscreveA=1 REscA=3 DadoA=0xDEADBEEF, RLe1=3 same cycle -> 0xDEADBEEF (bypass); next cycle EscreveA=0 -> still 0xDEADBEEF.
//  3 EscreveA REscA=7 DadoA=1 and EscreveB REscB=7 DadoB=2 same cycle: RLe1=7 -> 2 now and after edge.
//  4 EscreveB REscB=62 DadoB=0xFFFFFFFF: RLe2=62 reads 0 same cycle and after.
//  5 Write reg 9=0x1234, pulse reset_n low mid-sweep of a second reset: Pronto drops immediately.
//    Sweep restarts, takes 64 clocks; afterwards reg 9 reads 0 and reg 61 reads 255.
//  6 During INIT assert EscreveA REscA=4 DadoA=0x55: all DadoLe = 0; after Pronto, reg 4 reads 0.

Source files
------------

// File: rtl/banco_reg_param.sv
// banco_reg_param: parametrised MIPS register file with three combinational read ports,
// two write ports (A = ALU, B = memory, B wins on a shared address) and write-through bypass.
// After reset an init sweep writes every register (RA_IDX gets RA_INIT, all others 0);
// Pronto goes high once the sweep has finished.
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   RLe1/RLe2/RLe3         read addresses (rs, rt, rd)
//   EscreveA/REscA/DadoA   write port A: enable, address, data
//   EscreveB/REscB/DadoB   write port B: enable, address, data
//   DadoLe1/DadoLe2/DadoLe3 combinational read data
//   Pronto                 1 = sweep done, bank operational
module banco_reg_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int ZERO_IDX = 62,
    parameter int RA_IDX   = 61,
    parameter int RA_INIT  = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] RLe1,
    input  logic [ADDR_W-1:0] RLe2,
    input  logic [ADDR_W-1:0] RLe3,
    input  logic              EscreveA,
    input  logic [ADDR_W-1:0] REscA,
    input  logic [DATA_W-1:0] DadoA,
    input  logic              EscreveB,
    input  logic [ADDR_W-1:0] REscB,
    input  logic [DATA_W-1:0] DadoB,
    output logic [DATA_W-1:0] DadoLe1,
    output logic [DATA_W-1:0] DadoLe2,
    output logic [DATA_W-1:0] DadoLe3,
    output logic              Pronto
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] RA_A   = ADDR_W'(RA_IDX);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              run, we_a, we_b;
    logic [DATA_W-1:0] sweep_val;
    logic [ADDR_W-1:0] rle [3];
    logic [DATA_W-1:0] rdo [3];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The edge that sweeps the last register also moves the FSM to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        Pronto  = state_q == RUN;
        if (state_q == INIT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == '1) ? RUN : INIT;
        end
    end

    assign run       = state_q == RUN;
    assign we_a      = run && EscreveA && REscA != ZERO_A;
    assign we_b      = run && EscreveB && REscB != ZERO_A;
    assign sweep_val = (cnt_q == RA_A) ? DATA_W'(RA_INIT) : '0;

    // Array has no reset; port B is written last so it wins on a shared address.
    always_ff @(posedge clock) begin
        if (!run) begin
            mem_q[cnt_q] <= sweep_val;
        end else begin
            if (we_a) mem_q[REscA] <= DadoA;
            if (we_b) mem_q[REscB] <= DadoB;
        end
    end

    assign rle = '{RLe1, RLe2, RLe3};

    // Bypass priority mirrors the write priority so bypassed and stored values agree.
    for (genvar i = 0; i < 3; i++) begin : g_rd
        assign rdo[i] = (!run || rle[i] == ZERO_A) ? '0 :
                        (we_b && REscB == rle[i])  ? DadoB :
                        (we_a && REscA == rle[i])  ? DadoA : mem_q[rle[i]];
    end

    assign DadoLe1 = rdo[0];
    assign DadoLe2 = rdo[1];
    assign DadoLe3 = rdo[2];
endmodule

// File: tb/tb_banco_reg_param.sv
// tb_banco_reg_param: directed vector bench for banco_reg_param
module tb_banco_reg_param;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [5:0]  RLe1 = '0, RLe2 = '0, RLe3 = '0, REscA = '0, REscB = '0;
    logic        EscreveA = 1'b0, EscreveB = 1'b0;
    logic [31:0] DadoA = '0, DadoB = '0;
    logic [31:0] DadoLe1, DadoLe2, DadoLe3;
    logic        Pronto;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        ewa;
        logic [5:0]  wa;
        logic [31:0] da;
        logic        ewb;
        logic [5:0]  wb;
        logic [31:0] db;
        logic [5:0]  r1, r2, r3;
        logic [31:0] e1, e2, e3;
    } vec_t;

    vec_t vecs [13];

    banco_reg_param dut (
        .clock(clock), .reset_n(reset_n),
        .RLe1(RLe1), .RLe2(RLe2), .RLe3(RLe3),
        .EscreveA(EscreveA), .REscA(REscA), .DadoA(DadoA),
        .EscreveB(EscreveB), .REscB(REscB), .DadoB(DadoB),
        .DadoLe1(DadoLe1), .DadoLe2(DadoLe2), .DadoLe3(DadoLe3),
        .Pronto(Pronto)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        EscreveA = 1'b0;
        EscreveB = 1'b0;
    endtask

    // Counts rising edges (n carries edges already seen) until Pronto, bounded.
    task automatic wait_pronto(inout int n);
        while (!Pronto && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{0, 0, 0,            0, 0, 0,            61, 5, 62,  32'd255,      32'd0,        32'd0};
        vecs[1]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0,            3, 61, 0,   32'hDEADBEEF, 32'd255,      32'd0};
        vecs[2]  = '{0, 0, 0,            0, 0, 0,            3, 3, 4,    32'hDEADBEEF, 32'hDEADBEEF, 32'd0};
        vecs[3]  = '{1, 7, 32'd1,        1, 7, 32'd2,        7, 3, 61,   32'd2,        32'hDEADBEEF, 32'd255};
        vecs[4]  = '{0, 0, 0,            0, 0, 0,            7, 7, 3,    32'd2,        32'd2,        32'hDEADBEEF};
        vecs[5]  = '{0, 0, 0,            1, 62, 32'hFFFFFFFF, 62, 62, 7, 32'd0,        32'd0,        32'd2};
        vecs[6]  = '{0, 0, 0,            0, 0, 0,            62, 62, 62, 32'd0,        32'd0,        32'd0};
        vecs[7]  = '{1, 61, 32'hABC,     1, 10, 32'h77,      61, 10, 3,  32'hABC,      32'h77,       32'hDEADBEEF};
        vecs[8]  = '{0, 0, 0,            0, 0, 0,            61, 10, 7,  32'hABC,      32'h77,       32'd2};
        vecs[9]  = '{1, 62, 32'd5,       1, 8, 32'd9,        62, 8, 62,  32'd0,        32'd9,        32'd0};
        vecs[10] = '{1, 9, 32'h1234,     0, 0, 0,            9, 8, 62,   32'h1234,     32'd9,        32'd0};
        vecs[11] = '{1, 4, 32'h99,       0, 0, 0,            9, 4, 8,    32'h1234,     32'h99,       32'd9};
        vecs[12] = '{0, 0, 0,            0, 0, 0,            4, 9, 61,   32'h99,       32'h1234,     32'hABC};

        #2 reset_n = 1'b0;
        @(negedge clock);
        chk("pronto_in_reset", {31'd0, Pronto}, 32'd0);
        reset_n = 1'b1;
        #1 chk("pronto_at_release", {31'd0, Pronto}, 32'd0);
        n = 0;
        wait_pronto(n);
        chk("sweep_edges_1", n, 64);
        @(negedge clock);

        foreach (vecs[k]) begin
            EscreveA = vecs[k].ewa; REscA = vecs[k].wa; DadoA = vecs[k].da;
            EscreveB = vecs[k].ewb; REscB = vecs[k].wb; DadoB = vecs[k].db;
            RLe1 = vecs[k].r1; RLe2 = vecs[k].r2; RLe3 = vecs[k].r3;
            #1;
            chk($sformatf("v%0d_rd1", k), DadoLe1, vecs[k].e1);
            chk($sformatf("v%0d_rd2", k), DadoLe2, vecs[k].e2);
            chk($sformatf("v%0d_rd3", k), DadoLe3, vecs[k].e3);
            @(negedge clock);
        end
        idle();

        // Asynchronous reset from RUN drops Pronto without a clock edge.
        #2 reset_n = 1'b0;
        #1 chk("pronto_async_drop", {31'd0, Pronto}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        // Reset pulse mid-sweep restarts the sweep from register 0.
        #2 reset_n = 1'b0;
        #1 chk("pronto_midsweep_rst", {31'd0, Pronto}, 32'd0);
        reset_n = 1'b1;
        n = 0;
        repeat (10) @(posedge clock);
        n += 10;
        @(negedge clock);
        EscreveA = 1'b1; REscA = 6'd4; DadoA = 32'h55;
        RLe1 = 6'd4; RLe2 = 6'd61; RLe3 = 6'd9;
        #1;
        chk("init_rd1_zero", DadoLe1, 32'd0);
        chk("init_rd2_zero", DadoLe2, 32'd0);
        chk("init_rd3_zero", DadoLe3, 32'd0);
        @(posedge clock);
        n++;
        @(negedge clock);
        idle();
        wait_pronto(n);
        chk("sweep_edges_2", n, 64);
        @(negedge clock);
        RLe1 = 6'd9; RLe2 = 6'd61; RLe3 = 6'd4;
        #1;
        chk("post_sweep_r9", DadoLe1, 32'd0);
        chk("post_sweep_r61", DadoLe2, 32'd255);
        chk("post_sweep_r4", DadoLe3, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
